ex_issue_stage: RTL and testbench

EX_ISSUE_STAGE -- requirements
Module: ex_issue_stage

---
 rtl/ex_pkg.sv | 62 ++++++
 rtl/ex_scoreboard.sv | 69 ++++++
 rtl/ex_issue_stage.sv | 154 +++++++++++++++
 tb/tb_ex_issue_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared types, defaults and helpers for the EX issue stage.
// The optional writeback bypass is selected in the RTL by EX_ISSUE_FWD_EN.
package ex_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } ex_state_e;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1110;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
    logic [REG_AW_DEF-1:0] rs_a;
    logic [REG_AW_DEF-1:0] rs_b;
    logic [3:0]            alu_ctrl;
    logic [REG_AW_DEF-1:0] rd;
    logic                  wr_en;
  } issue_entry_t;

  // Register 0 is hardwired to zero whatever the register file presented.
  function automatic logic [DATA_W_DEF-1:0] src_operand(
    input logic [REG_AW_DEF-1:0] rs,
    input logic [DATA_W_DEF-1:0] val
  );
    logic [DATA_W_DEF-1:0] r;
    if (rs == {REG_AW_DEF{1'b0}}) r = {DATA_W_DEF{1'b0}};
    else                          r = val;
    return r;
  endfunction

  function automatic issue_entry_t wb_snoop(
    input issue_entry_t          e,
    input logic                  we,
    input logic [REG_AW_DEF-1:0] rd,
    input logic [DATA_W_DEF-1:0] data
  );
    issue_entry_t r;
    r = e;
    if (we && (rd != {REG_AW_DEF{1'b0}}) && (e.rs_a == rd)) r.a = data;
    else                                                    r.a = e.a;
    if (we && (rd != {REG_AW_DEF{1'b0}}) && (e.rs_b == rd)) r.b = data;
    else                                                    r.b = e.b;
    return r;
  endfunction

endpackage

// File: rtl/ex_scoreboard.sv
// Per-register pending bits plus the read-after-write hazard compare for
// the decode-side operands; EX_ISSUE_FWD_EN lets a same-cycle writeback resolve it.
module ex_scoreboard
  import ex_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en_i,
  input  logic [REG_AW-1:0] set_idx_i,
  input  logic              clr_en_i,
  input  logic [REG_AW-1:0] clr_idx_i,
  input  logic              chk_en_i,
  input  logic [REG_AW-1:0] rs_a_i,
  input  logic [REG_AW-1:0] rs_b_i,
  input  logic [1:0]        buf_wr_i,
  input  logic [REG_AW-1:0] buf_rd0_i,
  input  logic [REG_AW-1:0] buf_rd1_i,
  output logic              hazard_o
);

  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0]   pend_q, pend_d;
  logic [REG_AW-1:0] rs_s [2];
  logic [1:0]        wb_m_s, buf_m_s, pend_m_s, hit_s;

  assign rs_s[0] = rs_a_i;
  assign rs_s[1] = rs_b_i;

  // Pending-bit update: clear applied first so a same-index set wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_idx_i] = 1'b0;
    else          pend_d[clr_idx_i] = pend_q[clr_idx_i];
    if (set_en_i && (set_idx_i != '0)) pend_d[set_idx_i] = 1'b1;
    else                               pend_d[set_idx_i] = pend_d[set_idx_i];
  end

  // Hazard compare against pending registers and buffered destinations.
  always_comb begin
    wb_m_s   = 2'b00;
    buf_m_s  = 2'b00;
    pend_m_s = 2'b00;
    hit_s    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      wb_m_s[i]  = clr_en_i && (clr_idx_i == rs_s[i]);
      buf_m_s[i] = (buf_wr_i[0] && (buf_rd0_i == rs_s[i])) ||
                   (buf_wr_i[1] && (buf_rd1_i == rs_s[i]));
`ifdef EX_ISSUE_FWD_EN
      pend_m_s[i] = pend_q[rs_s[i]] && !wb_m_s[i];
`else
      pend_m_s[i] = pend_q[rs_s[i]] || wb_m_s[i];
`endif
      if (rs_s[i] != '0) hit_s[i] = pend_m_s[i] || buf_m_s[i];
      else               hit_s[i] = 1'b0;
    end
  end

  assign hazard_o = chk_en_i & (|hit_s);

  // Pending-bit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

endmodule

// File: rtl/ex_issue_stage.sv
// Two-entry in-order issue buffer between decode and the ALU with a register
// scoreboard interlock. Define EX_ISSUE_FWD_EN to enable writeback bypass/snoop.
module ex_issue_stage
  import ex_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [DATA_W-1:0] dec_a,
  input  logic [DATA_W-1:0] dec_b,
  input  logic [REG_AW-1:0] dec_rs_a,
  input  logic [REG_AW-1:0] dec_rs_b,
  input  logic [3:0]        dec_alu_ctrl,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_wr_en,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [3:0]        ex_alu_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_wr_en
);

  ex_state_e         state_q, state_d;
  logic              ready_q, ready_d;
  issue_entry_t      buf0_q, buf0_d, buf1_q, buf1_d;
  issue_entry_t      buf0_s, buf1_s, in_entry_s;
  logic              issue_s, accept_s, hazard_s;
  logic [DATA_W-1:0] op_a_s, op_b_s;
  logic [1:0]        buf_wr_s;

  assign ex_valid    = (state_q != ST_EMPTY);
  assign dec_ready   = ready_q & ~hazard_s & ~flush;
  assign issue_s     = ex_valid & ex_ready;
  assign accept_s    = dec_valid & dec_ready;
  assign ex_a        = buf0_q.a;
  assign ex_b        = buf0_q.b;
  assign ex_alu_ctrl = buf0_q.alu_ctrl;
  assign ex_rd       = buf0_q.rd;
  assign ex_wr_en    = buf0_q.wr_en;

  assign buf_wr_s[0] = ex_valid & buf0_q.wr_en;
  assign buf_wr_s[1] = (state_q == ST_TWO) & buf1_q.wr_en;

`ifdef EX_ISSUE_FWD_EN
  assign op_a_s = (wb_we && (wb_rd == dec_rs_a)) ? wb_data : dec_a;
  assign op_b_s = (wb_we && (wb_rd == dec_rs_b)) ? wb_data : dec_b;
  assign buf0_s = wb_snoop(buf0_q, wb_we, wb_rd, wb_data);
  assign buf1_s = wb_snoop(buf1_q, wb_we, wb_rd, wb_data);
`else
  logic unused_s;
  assign op_a_s   = dec_a;
  assign op_b_s   = dec_b;
  assign buf0_s   = buf0_q;
  assign buf1_s   = buf1_q;
  assign unused_s = ^{wb_data, buf0_q.rs_a, buf0_q.rs_b};
`endif

  // Incoming entry as it will sit in the buffer.
  always_comb begin
    in_entry_s          = '0;
    in_entry_s.a        = src_operand(dec_rs_a, op_a_s);
    in_entry_s.b        = src_operand(dec_rs_b, op_b_s);
    in_entry_s.rs_a     = dec_rs_a;
    in_entry_s.rs_b     = dec_rs_b;
    in_entry_s.alu_ctrl = dec_alu_ctrl;
    in_entry_s.rd       = dec_rd;
    in_entry_s.wr_en    = dec_wr_en;
  end

  ex_scoreboard #(.REG_AW(REG_AW)) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en_i  (issue_s & buf0_q.wr_en),
    .set_idx_i (buf0_q.rd),
    .clr_en_i  (wb_we),
    .clr_idx_i (wb_rd),
    .chk_en_i  (dec_valid),
    .rs_a_i    (dec_rs_a),
    .rs_b_i    (dec_rs_b),
    .buf_wr_i  (buf_wr_s),
    .buf_rd0_i (buf0_q.rd),
    .buf_rd1_i (buf1_q.rd),
    .hazard_o  (hazard_s)
  );

  // Occupancy FSM and entry movement; buf0 is always the head.
  always_comb begin
    state_d = state_q;
    buf0_d  = buf0_s;
    buf1_d  = buf1_s;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          buf0_d  = in_entry_s;
          state_d = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (issue_s && accept_s) begin
          buf0_d  = in_entry_s;
          state_d = ST_ONE;
        end else if (issue_s) begin
          state_d = ST_EMPTY;
        end else if (accept_s) begin
          buf1_d  = in_entry_s;
          state_d = ST_TWO;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_TWO: begin
        if (issue_s) begin
          buf0_d  = buf1_s;
          state_d = ST_ONE;
        end else begin
          state_d = ST_TWO;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // The head may still issue under flush; everything left is dropped.
    if (flush) state_d = ST_EMPTY;
    else       state_d = state_d;
    ready_d = (state_d != ST_TWO);
  end

  // State and buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

endmodule

// File: tb/tb_ex_issue_stage.sv
// Randomised and directed bench for ex_issue_stage against a queue-based model.
module tb_ex_issue_stage;
`ifdef EX_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_valid = 1'b0, dec_ready, dec_wr_en = 1'b0;
  logic [31:0] dec_a = 32'd0, dec_b = 32'd0, wb_data = 32'd0;
  logic [3:0]  dec_rs_a = 4'd0, dec_rs_b = 4'd0, dec_alu_ctrl = 4'd0, dec_rd = 4'd0;
  logic        flush = 1'b0, wb_we = 1'b0, ex_ready = 1'b0;
  logic [3:0]  wb_rd = 4'd0;
  logic        ex_valid, ex_wr_en;
  logic [31:0] ex_a, ex_b;
  logic [3:0]  ex_alu_ctrl, ex_rd;

  ex_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_a(dec_a), .dec_b(dec_b), .dec_rs_a(dec_rs_a), .dec_rs_b(dec_rs_b),
    .dec_alu_ctrl(dec_alu_ctrl), .dec_rd(dec_rd), .dec_wr_en(dec_wr_en),
    .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_a(ex_a), .ex_b(ex_b),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  rs_a, rs_b, ctrl, rd;
    logic        wr;
  } ent_t;

  ent_t q[$];
  bit   pend [16];
  bit   ready_m = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] payload();
    return {55'd0, ex_a, ex_b, ex_alu_ctrl, ex_rd, ex_wr_en};
  endfunction

  function automatic logic [127:0] ent_payload(input ent_t e);
    return {55'd0, e.a, e.b, e.ctrl, e.rd, e.wr};
  endfunction

  function automatic bit haz(input logic [3:0] rs);
    bit wbm;
    if (rs == 4'd0) return 1'b0;
    foreach (q[i]) if (q[i].wr && q[i].rd == rs) return 1'b1;
    wbm = wb_we && (wb_rd == rs);
    return FWD ? (pend[rs] && !wbm) : (pend[rs] || wbm);
  endfunction

  function automatic bit exp_ready();
    return ready_m && !flush && !(dec_valid && (haz(dec_rs_a) || haz(dec_rs_b)));
  endfunction

  function automatic logic [31:0] opnd(input logic [3:0] rs, input logic [31:0] val);
    if (rs == 4'd0) return 32'd0;
    if (FWD && wb_we && wb_rd == rs) return wb_data;
    return val;
  endfunction

  task automatic model_reset();
    q.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    ready_m = 1'b0;
  endtask

  // One clock: compare at negedge+2 (or +3), then advance the model across the edge.
  task automatic cycle();
    bit acc, iss, fl, wbwe;
    logic [3:0] wbrd;
    logic [31:0] wbdata;
    ent_t e;
    #2;
    if (!rst_n) begin
      chk("rst_dec_ready", dec_ready, 1'b0);
      chk("rst_ex_valid", ex_valid, 1'b0);
      chk("rst_payload", payload(), 128'd0);
      @(posedge clk);
      @(negedge clk);
      return;
    end
    acc = dec_valid && exp_ready();
    iss = (q.size() != 0) && ex_ready;
    chk("dec_ready", dec_ready, exp_ready());
    chk("ex_valid", ex_valid, q.size() != 0);
    if (q.size() != 0) chk("ex_payload", payload(), ent_payload(q[0]));
    e = '{opnd(dec_rs_a, dec_a), opnd(dec_rs_b, dec_b), dec_rs_a, dec_rs_b,
          dec_alu_ctrl, dec_rd, dec_wr_en};
    fl = flush; wbwe = wb_we; wbrd = wb_rd; wbdata = wb_data;
    @(posedge clk);
    if (wbwe) pend[wbrd] = 1'b0;
    if (iss) begin
      if (q[0].wr && q[0].rd != 4'd0) pend[q[0].rd] = 1'b1;
      void'(q.pop_front());
    end
    if (FWD && wbwe && wbrd != 4'd0) begin
      foreach (q[i]) begin
        if (q[i].rs_a == wbrd) q[i].a = wbdata;
        if (q[i].rs_b == wbrd) q[i].b = wbdata;
      end
    end
    if (acc) q.push_back(e);
    if (fl) q.delete();
    ready_m = (q.size() != 2);
    @(negedge clk);
  endtask

  task automatic set_dec(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] ctrl,
                         input logic [3:0] rd, input logic wr);
    dec_valid = v; dec_a = a; dec_b = b; dec_rs_a = ra; dec_rs_b = rb;
    dec_alu_ctrl = ctrl; dec_rd = rd; dec_wr_en = wr;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ex_valid", ex_valid, 1'b0);
    chk("reset_dec_ready", dec_ready, 1'b0);
    chk("reset_payload", payload(), 128'd0);
    rst_n = 1'b1;
    cycle();

    // Basic accept with one-cycle latency.
    set_dec(1'b1, 32'd5, 32'd7, 4'd1, 4'd2, 4'b1110, 4'd3, 1'b1);
    ex_ready = 1'b0;
    cycle();
    dec_valid = 1'b0;
    #1;
    chk("lat_ex_valid", ex_valid, 1'b1);
    chk("lat_ex_a", ex_a, 32'd5);
    chk("lat_ex_b", ex_b, 32'd7);
    chk("lat_ctrl", ex_alu_ctrl, 4'b1110);
    chk("lat_rd", ex_rd, 4'd3);
    cycle();

    // Fill to two entries with ex_ready low, then drain in order.
    ex_ready = 1'b1;
    cycle();
    ex_ready = 1'b0;
    set_dec(1'b1, 32'd11, 32'd1, 4'd1, 4'd2, 4'd0, 4'd1, 1'b0);
    cycle();
    set_dec(1'b1, 32'd22, 32'd2, 4'd1, 4'd2, 4'd0, 4'd1, 1'b0);
    cycle();
    set_dec(1'b1, 32'd33, 32'd3, 4'd1, 4'd2, 4'd0, 4'd1, 1'b0);
    #1;
    chk("two_ready_low", dec_ready, 1'b0);
    chk("two_head_a", ex_a, 32'd11);
    cycle();
    ex_ready = 1'b1;
    #1;
    chk("drain0_a", ex_a, 32'd11);
    chk("drain0_ready", dec_ready, 1'b0);
    cycle();
    #1;
    chk("drain1_a", ex_a, 32'd22);
    chk("drain1_ready", dec_ready, 1'b1);
    cycle();
    dec_valid = 1'b0;
    #1;
    chk("drain2_a", ex_a, 32'd33);
    cycle();

    // Read-after-write interlock released by writeback.
    set_dec(1'b1, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0, 4'd2, 1'b1);
    cycle();
    dec_valid = 1'b0;
    cycle();
    ex_ready = 1'b0;
    set_dec(1'b1, 32'd99, 32'd0, 4'd2, 4'd0, 4'd0, 4'd0, 1'b0);
    #1;
    chk("raw_block", dec_ready, 1'b0);
    cycle();
    wb_we = 1'b1; wb_rd = 4'd2; wb_data = 32'h0000_ABCD;
    #1;
    chk("raw_wb_cycle", dec_ready, FWD);
    cycle();
    wb_we = 1'b0;
    dec_valid = !FWD;
    #1;
    chk("raw_wb_next_valid", ex_valid, FWD);
    cycle();
    dec_valid = 1'b0;
    #1;
    chk("raw_issue_valid", ex_valid, 1'b1);
    chk("raw_issue_a", ex_a, FWD ? 32'h0000_ABCD : 32'd99);
    cycle();

    // Flush in TWO with ex_ready: head issues, tail dropped, scoreboard kept.
    ex_ready = 1'b1;
    cycle();
    ex_ready = 1'b0;
    set_dec(1'b1, 32'h77, 32'd0, 4'd1, 4'd0, 4'd0, 4'd7, 1'b1);
    cycle();
    set_dec(1'b1, 32'h55, 32'd0, 4'd1, 4'd0, 4'd0, 4'd5, 1'b1);
    cycle();
    set_dec(1'b1, 32'h66, 32'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    flush = 1'b1; ex_ready = 1'b1;
    #1;
    chk("flush_ready", dec_ready, 1'b0);
    chk("flush_head_a", ex_a, 32'h77);
    cycle();
    flush = 1'b0; ex_ready = 1'b0;
    set_dec(1'b1, 32'd0, 32'd0, 4'd5, 4'd0, 4'd0, 4'd0, 1'b0);
    #1;
    chk("flush_empty", ex_valid, 1'b0);
    chk("flush_dropped_no_pend", dec_ready, 1'b1);
    dec_rs_a = 4'd7;
    #1;
    chk("flush_head_pend", dec_ready, 1'b0);
    dec_valid = 1'b0;
    cycle();

    // Source index 0 forces a zero operand.
    set_dec(1'b1, 32'd3, 32'hFFFF_FFFF, 4'd1, 4'd0, 4'd0, 4'd6, 1'b1);
    cycle();
    set_dec(1'b1, 32'd9, 32'd9, 4'd1, 4'd1, 4'd0, 4'd0, 1'b0);
    ex_ready = 1'b1;
    #1;
    chk("r0_ex_b", ex_b, 32'd0);
    chk("r0_ex_a", ex_a, 32'd3);
    cycle();

    // Asynchronous reset while in ONE with register 6 pending.
    ex_ready = 1'b0; dec_valid = 1'b0;
    #1;
    chk("pre_reset_valid", ex_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", ex_valid, 1'b0);
    chk("async_rst_ready", dec_ready, 1'b0);
    chk("async_rst_payload", payload(), 128'd0);
    model_reset();
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    set_dec(1'b1, 32'd1, 32'd0, 4'd6, 4'd0, 4'd0, 4'd0, 1'b0);
    #1;
    chk("release_ready_low", dec_ready, 1'b0);
    cycle();
    #1;
    chk("sb_cleared_ready", dec_ready, 1'b1);
    cycle();
    dec_valid = 1'b0; ex_ready = 1'b1;
    cycle();

    // Randomised traffic on a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      set_dec(1'($urandom_range(0, 1)), $urandom(), $urandom(),
              4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
      flush    = ($urandom_range(0, 15) == 0);
      wb_we    = ($urandom_range(0, 2) == 0);
      wb_rd    = 4'($urandom_range(0, 3));
      wb_data  = $urandom();
      ex_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
